// File: rtl/sample_delay_line_pkg.sv
// rtl/sample_delay_line_pkg.sv - shared types and sizing helpers for the tapped delay line
package sample_delay_line_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } dl_state_t;

    // Width able to hold 0..depth, used for both the fill level and the flush counter.
    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sample_delay_line_shift_strobe_det.sv
// rtl/sample_delay_line_shift_strobe_det.sv - rising-edge qualifier for the shift strobe (SAMPLE_DELAY_LINE_EDGE_DET_EN only)
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   shift   : raw shift level
//   strobe  : high on the first cycle shift reads 1 after reading 0
`ifdef SAMPLE_DELAY_LINE_EDGE_DET_EN
module shift_strobe_det (
    input  logic clk,
    input  logic reset_n,
    input  logic shift,
    output logic strobe
);

    logic shift_q;

    // Reset to 1 so a shift held high through reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q <= 1'b1;
        end else begin
            shift_q <= shift;
        end
    end

    assign strobe = shift & ~shift_q;

endmodule
`endif

// File: rtl/sample_delay_line.sv
// rtl/sample_delay_line.sv - tapped delay line with flush sequencing and fill status; option macro SAMPLE_DELAY_LINE_EDGE_DET_EN
//   clk       : system clock, rising edge
//   reset_n   : synchronous active-low reset
//   shift     : sample strobe (edge-qualified when SAMPLE_DELAY_LINE_EDGE_DET_EN is defined)
//   clear     : start a flush of all taps
//   data_in   : 2N-bit sample to load
//   taps      : tap i at [i*2N +: 2N], tap 0 newest
//   tap_valid : one-cycle pulse after a sample was shifted in
//   fill      : number of valid taps, saturating at DEPTH
//   primed    : fill == DEPTH
//   busy      : flush in progress, shift ignored
module sample_delay_line
    import sample_delay_line_pkg::*;
#(
    parameter int N     = 25,
    parameter int DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        shift,
    input  logic                        clear,
    input  logic [2*N-1:0]              data_in,
    output logic [2*N*DEPTH-1:0]        taps,
    output logic                        tap_valid,
    output logic [fill_w(DEPTH)-1:0]    fill,
    output logic                        primed,
    output logic                        busy
);

    localparam int W  = 2 * N;
    localparam int FW = fill_w(DEPTH);
    localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
    localparam logic [FW-1:0] LAST_F  = FW'(DEPTH - 1);

    logic strobe;

`ifdef SAMPLE_DELAY_LINE_EDGE_DET_EN
    shift_strobe_det u_strobe_det (
        .clk     (clk),
        .reset_n (reset_n),
        .shift   (shift),
        .strobe  (strobe)
    );
`else
    assign strobe = shift;
`endif

    dl_state_t       state, state_next;
    logic [FW-1:0]   cnt, cnt_next;
    logic [FW-1:0]   fill_q, fill_next;
    logic            tv_q, tv_next;
    logic            chain_en;
    logic            load_zero;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= RUN;
            cnt    <= '0;
            fill_q <= '0;
            tv_q   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            fill_q <= fill_next;
            tv_q   <= tv_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fill_next  = fill_q;
        tv_next    = 1'b0;
        chain_en   = 1'b0;
        load_zero  = 1'b0;
        case (state)
            RUN: begin
                // clear has priority; a coincident sample is dropped.
                if (clear) begin
                    state_next = FLUSH;
                    cnt_next   = LAST_F;
                    fill_next  = '0;
                end else if (strobe) begin
                    chain_en = 1'b1;
                    tv_next  = 1'b1;
                    if (fill_q != DEPTH_F) begin
                        fill_next = fill_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Zeros are walked through the chain; no parallel clear of the taps.
                chain_en  = 1'b1;
                load_zero = 1'b1;
                if (clear) begin
                    cnt_next = LAST_F;
                end else if (cnt == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    logic [W-1:0] tap_r [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        if (g == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    tap_r[0] <= '0;
                end else if (chain_en) begin
                    tap_r[0] <= load_zero ? '0 : data_in;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    tap_r[g] <= '0;
                end else if (chain_en) begin
                    tap_r[g] <= tap_r[g-1];
                end
            end
        end
        assign taps[g*W +: W] = tap_r[g];
    end

    assign tap_valid = tv_q;
    assign fill      = fill_q;
    assign primed    = (fill_q == DEPTH_F);
    assign busy      = (state == FLUSH);

endmodule

// File: tb/tb_sample_delay_line.sv
// tb/tb_sample_delay_line.sv - scoreboard bench for sample_delay_line against a queue-based reference model
module tb_sample_delay_line;

    localparam int N     = 25;
    localparam int DEPTH = 3;
    localparam int W     = 2 * N;
    localparam int CW    = W * DEPTH;
    localparam int FW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset_n;
    logic            shift;
    logic            clear;
    logic [W-1:0]    data_in;
    logic [CW-1:0]   taps;
    logic            tap_valid;
    logic [FW-1:0]   fill;
    logic            primed;
    logic            busy;

    always #5 clk = ~clk;

    sample_delay_line #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .shift     (shift),
        .clear     (clear),
        .data_in   (data_in),
        .taps      (taps),
        .tap_valid (tap_valid),
        .fill      (fill),
        .primed    (primed),
        .busy      (busy)
    );

    typedef struct {
        logic [CW-1:0] taps;
        logic          tv;
        logic [FW-1:0] fill;
        logic          primed;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: history of the last DEPTH samples, newest first.
    logic [W-1:0] hist[$];
    int           m_fill;
    int           m_left;
    logic         m_prev;
    logic         m_tv;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back('0);
        m_fill = 0;
        m_left = 0;
        m_prev = 1'b1;
        m_tv   = 1'b0;
    endfunction

    function automatic void push_sample(input logic [W-1:0] v);
        hist.push_front(v);
        void'(hist.pop_back());
    endfunction

    function automatic void model_edge(input logic r, input logic s, input logic c, input logic [W-1:0] d);
        logic stb;
        exp_t e;
        if (!r) begin
            model_reset();
        end else begin
`ifdef SAMPLE_DELAY_LINE_EDGE_DET_EN
            stb = s && !m_prev;
`else
            stb = s;
`endif
            m_prev = s;
            m_tv   = 1'b0;
            if (m_left > 0) begin
                push_sample('0);
                m_left = c ? DEPTH : m_left - 1;
            end else if (c) begin
                m_left = DEPTH;
                m_fill = 0;
            end else if (stb) begin
                push_sample(d);
                m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
                m_tv   = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) e.taps[i*W +: W] = hist[i];
        e.tv     = m_tv;
        e.fill   = FW'(m_fill);
        e.primed = (m_fill == DEPTH);
        e.busy   = (m_left > 0);
        exp_q.push_back(e);
    endfunction

    function automatic void chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endfunction

    task automatic step(input logic r, input logic s, input logic c, input logic [W-1:0] d);
        reset_n = r;
        shift   = s;
        clear   = c;
        data_in = d;
        @(posedge clk);
        model_edge(r, s, c, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
    endtask

    // Monitor: one expectation per clock edge, compared away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("taps",      taps,          e.taps);
                chk("tap_valid", CW'(tap_valid), CW'(e.tv));
                chk("fill",      CW'(fill),      CW'(e.fill));
                chk("primed",    CW'(primed),    CW'(e.primed));
                chk("busy",      CW'(busy),      CW'(e.busy));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rnd;
        reset_n = 1'b0;
        shift   = 1'b0;
        clear   = 1'b0;
        data_in = '0;
        model_reset();

        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        step(1'b1, 1'b1, 1'b0, W'(5));  idle(1);
        step(1'b1, 1'b1, 1'b0, W'(7));  idle(1);
        step(1'b1, 1'b1, 1'b0, W'(9));  idle(1);
        step(1'b1, 1'b1, 1'b0, W'(11)); idle(1);

        step(1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b0, W'('h55));
        idle(3);

        step(1'b1, 1'b1, 1'b0, W'(3)); idle(1);
        step(1'b1, 1'b1, 1'b1, W'('h1234));
        idle(4);

        step(1'b1, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, W'('h77));
        idle(1);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, W'(100 + i));
        idle(1);

        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom(), $urandom()};
            step($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0, rnd[W-1:0]);
        end
        idle(2);

        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
